// File: rtl/warp_scheduler.sv
// ----------------------------------------------------------------------------
// warp_scheduler
//
// Per-core warp scheduler. Launches up to MAX_WARPS warps for a thread block,
// tracks each warp's PC and status, and offers one READY warp at a time to the
// fetch/decode front end. Selection is round-robin and skips warps that are
// in flight, waiting on memory, finished or not launched.
//
// Ports:
//   clk              - clock, rising edge
//   reset            - asynchronous, active-low reset
//   start            - launch pulse, honoured in IDLE or DONE only
//   thread_count     - threads in the block, sampled with start
//   issue_valid      - issue slot holds a READY warp
//   issue_ready      - fetcher accepts the slot
//   issue_warp_id    - warp in the slot
//   issue_pc         - PC of the warp in the slot
//   issue_mask       - active-thread mask of the warp in the slot
//   commit_valid     - an in-flight warp finished its instruction
//   commit_warp_id   - committing warp
//   commit_pc        - next PC for the committing warp
//   commit_ret       - the instruction was RET, warp finishes
//   commit_mem       - warp must wait for outstanding LSU traffic
//   mem_done_valid   - LSU traffic of a warp completed
//   mem_done_warp_id - warp whose memory traffic completed
//   done             - every launched warp has finished
//   error            - sticky protocol/configuration error
// ----------------------------------------------------------------------------
module warp_scheduler #(
    parameter int MAX_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4,
    parameter int PC_WIDTH         = 8,
    localparam int WID_W           = $clog2(MAX_WARPS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [7:0]                  thread_count,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [WID_W-1:0]            issue_warp_id,
    output logic [PC_WIDTH-1:0]         issue_pc,
    output logic [THREADS_PER_WARP-1:0] issue_mask,
    input  logic                        commit_valid,
    input  logic [WID_W-1:0]            commit_warp_id,
    input  logic [PC_WIDTH-1:0]         commit_pc,
    input  logic                        commit_ret,
    input  logic                        commit_mem,
    input  logic                        mem_done_valid,
    input  logic [WID_W-1:0]            mem_done_warp_id,
    output logic                        done,
    output logic                        error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sched_state_t;

    typedef enum logic [2:0] {
        W_INACTIVE,
        W_READY,
        W_IN_FLIGHT,
        W_MEM_WAIT,
        W_FINISHED
    } warp_state_t;

    sched_state_t                  state_reg;
    warp_state_t                   warp_state_reg [MAX_WARPS];
    logic [PC_WIDTH-1:0]           pc_reg         [MAX_WARPS];
    logic [THREADS_PER_WARP-1:0]   mask_reg       [MAX_WARPS];
    logic [WID_W-1:0]              rr_ptr_reg;

    logic                          issue_valid_reg;
    logic [WID_W-1:0]              issue_warp_id_reg;
    logic [PC_WIDTH-1:0]           issue_pc_reg;
    logic [THREADS_PER_WARP-1:0]   issue_mask_reg;
    logic                          done_reg;
    logic                          error_reg;

    assign issue_valid   = issue_valid_reg;
    assign issue_warp_id = issue_warp_id_reg;
    assign issue_pc      = issue_pc_reg;
    assign issue_mask    = issue_mask_reg;
    assign done          = done_reg;
    assign error         = error_reg;

    // ------------------------------------------------------------------
    // Launch decode: warp count and mask of the (possibly partial) last warp,
    // all in 9-bit arithmetic so thread_count=255 cannot overflow.
    // ------------------------------------------------------------------
    logic [8:0]                  tc_ext;
    logic [8:0]                  n_warps;
    logic [8:0]                  last_rem;
    logic [THREADS_PER_WARP-1:0] last_mask;
    logic                        start_ok;
    logic                        launch;
    logic                        too_many;

    assign tc_ext   = {1'b0, thread_count};
    assign n_warps  = (tc_ext + 9'(THREADS_PER_WARP - 1)) / 9'(THREADS_PER_WARP);
    // Threads in the last warp (1..THREADS_PER_WARP); only used when n_warps >= 1.
    assign last_rem = tc_ext - (n_warps - 9'd1) * 9'(THREADS_PER_WARP);

    for (genvar gi = 0; gi < THREADS_PER_WARP; gi++) begin : g_last_mask
        assign last_mask[gi] = (9'(gi) < last_rem);
    end

    assign start_ok = start && (state_reg != S_RUN);
    assign launch   = start_ok && (n_warps != 9'd0) && (n_warps <= 9'(MAX_WARPS));
    assign too_many = start_ok && (n_warps > 9'(MAX_WARPS));

    // ------------------------------------------------------------------
    // Handshake and feedback qualification
    // ------------------------------------------------------------------
    logic handshake;
    logic load_slot;
    logic commit_legal;
    logic md_clash;
    logic md_legal;
    logic proto_err;

    assign handshake = issue_valid_reg && issue_ready;
    assign load_slot = !issue_valid_reg || handshake;

    assign commit_legal = commit_valid && (warp_state_reg[commit_warp_id] == W_IN_FLIGHT);
    // Commit and mem_done naming the same warp: commit wins, mem_done is dropped.
    assign md_clash     = mem_done_valid && commit_valid && (mem_done_warp_id == commit_warp_id);
    assign md_legal     = mem_done_valid && !md_clash &&
                          (warp_state_reg[mem_done_warp_id] == W_MEM_WAIT);
    assign proto_err    = (commit_valid && !commit_legal) ||
                          md_clash ||
                          (mem_done_valid && !md_clash && !md_legal);

    // ------------------------------------------------------------------
    // Round-robin candidate search over registered warp state. The warp
    // leaving the slot this cycle is still READY in the registers, so it is
    // excluded explicitly.
    // ------------------------------------------------------------------
    logic             cand_found;
    logic [WID_W-1:0] cand_id;
    logic [WID_W-1:0] scan_idx;

    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        scan_idx   = '0;
        for (int k = 1; k <= MAX_WARPS; k++) begin
            scan_idx = rr_ptr_reg + WID_W'(k);
            if (!cand_found && (warp_state_reg[scan_idx] == W_READY) &&
                !(handshake && (scan_idx == issue_warp_id_reg))) begin
                cand_found = 1'b1;
                cand_id    = scan_idx;
            end
        end
    end

    // Launched warps are never INACTIVE, so this is true once all are FINISHED.
    logic all_retired;

    always_comb begin
        all_retired = 1'b1;
        for (int w = 0; w < MAX_WARPS; w++) begin
            if ((warp_state_reg[w] != W_INACTIVE) && (warp_state_reg[w] != W_FINISHED)) begin
                all_retired = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-warp status, PC and mask
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < MAX_WARPS; w++) begin
                warp_state_reg[w] <= W_INACTIVE;
                pc_reg[w]         <= '0;
                mask_reg[w]       <= '0;
            end
        end else if (start_ok) begin
            for (int w = 0; w < MAX_WARPS; w++) begin
                pc_reg[w] <= '0;
                if (launch && (9'(w) < n_warps)) begin
                    warp_state_reg[w] <= W_READY;
                    mask_reg[w]       <= (9'(w) == n_warps - 9'd1) ? last_mask : '1;
                end else begin
                    warp_state_reg[w] <= W_INACTIVE;
                    mask_reg[w]       <= '0;
                end
            end
        end else begin
            // Each event only touches a warp in a distinct state, so at most
            // one of these updates can apply to any one warp.
            for (int w = 0; w < MAX_WARPS; w++) begin
                if (handshake && (issue_warp_id_reg == WID_W'(w))) begin
                    warp_state_reg[w] <= W_IN_FLIGHT;
                end
                if (commit_legal && (commit_warp_id == WID_W'(w))) begin
                    if (commit_ret) begin
                        warp_state_reg[w] <= W_FINISHED;
                    end else begin
                        pc_reg[w]         <= commit_pc;
                        warp_state_reg[w] <= commit_mem ? W_MEM_WAIT : W_READY;
                    end
                end
                if (md_legal && (mem_done_warp_id == WID_W'(w))) begin
                    warp_state_reg[w] <= W_READY;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Top FSM, issue slot, round-robin pointer, done and error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= S_IDLE;
            rr_ptr_reg        <= WID_W'(MAX_WARPS - 1);
            issue_valid_reg   <= 1'b0;
            issue_warp_id_reg <= '0;
            issue_pc_reg      <= '0;
            issue_mask_reg    <= '0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            if (proto_err || too_many) begin
                error_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE, S_DONE: begin
                    issue_valid_reg <= 1'b0;
                    if (start_ok) begin
                        if (launch) begin
                            state_reg  <= S_RUN;
                            done_reg   <= 1'b0;
                            // Restart the scan so warp 0 is offered first.
                            rr_ptr_reg <= WID_W'(MAX_WARPS - 1);
                        end else begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (handshake) begin
                        rr_ptr_reg <= issue_warp_id_reg;
                    end
                    if (all_retired) begin
                        state_reg       <= S_DONE;
                        done_reg        <= 1'b1;
                        issue_valid_reg <= 1'b0;
                    end else if (load_slot) begin
                        issue_valid_reg <= cand_found;
                        if (cand_found) begin
                            issue_warp_id_reg <= cand_id;
                            issue_pc_reg      <= pc_reg[cand_id];
                            issue_mask_reg    <= mask_reg[cand_id];
                        end
                    end
                end

                default: begin
                    state_reg       <= S_IDLE;
                    issue_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Per-core warp scheduler. Tracks up to MAX_WARPS warps, each with its own PC and status, and issues one ready warp at a time to the fetch/decode front end over a valid/ready handshake.
- Round-robin selection skips warps that are stalled on memory or finished. Supports partial last warps through a thread mask.
- Sits between the core's dispatch interface and the fetcher. Commit and LSU-completion feedback come from the execute stage.

Parameters:
- MAX_WARPS, 4, warp slots per core (power of 2, ≥2); WID_W = clog2(MAX_WARPS) is a localparam
- THREADS_PER_WARP, 4, threads per warp and width of the thread mask
- PC_WIDTH, 8, program counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch pulse; sampled in IDLE or DONE
- thread_count  in  8  threads in the block, sampled on start
- issue_valid  out  1  an issue slot holds a ready warp
- issue_ready  in  1  fetcher accepts the slot
- issue_warp_id  out  WID_W  warp being issued
- issue_pc  out  PC_WIDTH  PC of the issued warp
- issue_mask  out  THREADS_PER_WARP  active threads of the issued warp
- commit_valid  in  1  in-flight warp finished its instruction
- commit_warp_id  in  WID_W  committing warp
- commit_pc  in  PC_WIDTH  next PC for the committing warp
- commit_ret  in  1  instruction was RET; warp finishes
- commit_mem  in  1  warp waits on outstanding LSU traffic
- mem_done_valid  in  1  LSU traffic completed
- mem_done_warp_id  in  WID_W  warp whose memory completed
- done  out  1  all launched warps finished
- error  out  1  sticky protocol/config error

Behaviour:
- Reset (reset=0, async): state=IDLE, all warps INACTIVE, all PCs 0, rr_ptr=MAX_WARPS-1. Outputs issue_valid=0, issue_warp_id=0, issue_pc=0, issue_mask=0, done=0, error=0.
- Top FSM: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Compute N = ceil(thread_count/THREADS_PER_WARP) in 9-bit arithmetic.
  - N=0: go to DONE; done=1 next cycle.
  - N>MAX_WARPS: error<=1, go to DONE, no warps launched.
  - Otherwise: warps 0..N-1 become READY with PC=0; the rest stay INACTIVE; done<=0; go to RUN.
- Start in RUN is ignored.
- Warp mask: all ones for warps 0..N-2. Warp N-1 gets the low R bits set, where R = thread_count - (N-1)*THREADS_PER_WARP.
- Per-warp states: INACTIVE, READY, IN_FLIGHT, MEM_WAIT, FINISHED.
- Issue slot (registered outputs):
  - Load when issue_valid=0, or on a handshake (issue_valid & issue_ready).
  - Candidate = first READY warp scanning rr_ptr+1, rr_ptr+2, ... modulo MAX_WARPS, excluding the warp being handed off this cycle.
  - No candidate: issue_valid<=0.
- Slot stability: while issue_valid=1 and issue_ready=0, issue_warp_id, issue_pc and issue_mask are held stable.
- Handshake: the slot warp goes READY→IN_FLIGHT and rr_ptr<=issue_warp_id. A new warp can be presented the very next cycle.
- Selection uses registered warp state. A warp made READY at edge N is issuable at the earliest on the slot loaded at edge N+1. Minimum READY→issue_valid latency is 1 cycle.
- At most one warp is in the slot; a warp in the slot stays READY until its handshake.
- Commit (only if warp is IN_FLIGHT):
  - commit_ret=1: warp→FINISHED.
  - commit_ret=0, commit_mem=1: PC<=commit_pc, warp→MEM_WAIT.
  - commit_ret=0, commit_mem=0: PC<=commit_pc, warp→READY.
  - commit_ret has priority over commit_mem.
- mem_done (only if warp is MEM_WAIT): warp→READY.
- Simultaneous events:
  - Commit, mem_done and handshake on distinct warps in one cycle all apply.
  - commit_warp_id == mem_done_warp_id in the same cycle is illegal: commit applies, mem_done is dropped, error<=1.
- Protocol errors: commit to a non-IN_FLIGHT warp, or mem_done to a non-MEM_WAIT warp, is ignored and sets error<=1. error clears only on reset.
- Completion: in RUN, when every launched warp is FINISHED, go to DONE next edge. done is 1 in DONE and issue_valid is 0.
- Wrap-around: rr_ptr and the scan wrap modulo MAX_WARPS. PCs wrap modulo 2^PC_WIDTH; no overflow detection.

Test Plan:
- Launch: thread_count=10, TPW=4, MAX=4 → warps 0,1,2 launched. First issue is warp 0, pc 0, mask 1111. Warp 2 mask 0011. Warp 3 is never issued.
- Round-robin: issue_ready=1 always; each commit is pc+1, no ret/mem → issue order 0,1,2,0,1,2…, each warp's PC increments per issue.
- Backpressure: issue_ready=0 for 5 cycles with warp 1 in the slot → id, pc and mask are unchanged every cycle; on acceptance warp 1 becomes IN_FLIGHT.
- Memory stall: warp 0 commits with commit_mem=1, pc=7 → warp 0 is skipped until mem_done(0); it is then issued with pc 7 no earlier than 1 cycle later.
- Completion and errors:
  - All warps commit_ret → done=1 and issue_valid=0.
  - thread_count=17 (N=5) → done=1, error=1.
  - thread_count=0 → done=1, error=0.
  - A commit to a READY warp → error=1, warp state unchanged.
- Async reset mid-RUN: drop reset between clock edges → all outputs are 0 immediately. After release, start relaunches with all PCs 0.
